// File: rtl/mac_accumulator.sv
// ============================================================================
//  Module   : mac_accumulator (with helper module multiplier)
//  Function : Pipelined multiply-accumulate over last-terminated bursts,
//             result held on a valid/ready port. Optional MAC_SATURATE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiplier #(
    parameter int bit_width = 8
) (
    input  logic [bit_width-1:0] a,
    input  logic [bit_width-1:0] b,
    output logic [bit_width-1:0] product
);
    assign product = a * b;
endmodule

module mac_accumulator #(
    parameter int bit_width = 8,
    parameter int acc_width = 16,
    parameter int cnt_width = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [bit_width-1:0] in_a,
    input  logic [bit_width-1:0] in_b,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [acc_width-1:0] out_sum,
    output logic [cnt_width-1:0] out_count,
    output logic                 out_ovf
);
    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [bit_width-1:0] w_prod;
    logic [acc_width-1:0] w_prod_ext;
    logic                 w_in_hs;
    logic                 w_out_hs;
    logic [acc_width:0]   w_sum_full;
    logic                 w_carry;
    logic [acc_width-1:0] w_acc_next;

    logic [acc_width-1:0] r_p;
    logic                 r_p_valid;
    logic [acc_width-1:0] r_acc;
    logic [cnt_width-1:0] r_cnt;
    logic                 r_ovf;
    logic                 r_out_valid;
    logic [acc_width-1:0] r_out_sum;
    logic [cnt_width-1:0] r_out_count;
    logic                 r_out_ovf;

    multiplier #(.bit_width(bit_width)) u_mult (
        .a       (in_a),
        .b       (in_b),
        .product (w_prod)
    );

    assign w_prod_ext = acc_width'(w_prod);
    assign in_ready   = (r_state == ST_ACCUM);
    assign w_in_hs    = in_valid && in_ready;
    assign w_out_hs   = r_out_valid && out_ready;

    assign w_sum_full = {1'b0, r_acc} + {1'b0, r_p};
    assign w_carry    = w_sum_full[acc_width];

`ifdef MAC_SATURATE_EN
    assign w_acc_next = w_carry ? {acc_width{1'b1}} : w_sum_full[acc_width-1:0];
`else
    assign w_acc_next = w_sum_full[acc_width-1:0];
`endif

    // DRAIN waits until the last product has been folded into r_acc.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ACCUM: if (w_in_hs && in_last) w_state_next = ST_DRAIN;
            ST_DRAIN: if (!r_p_valid)         w_state_next = ST_HOLD;
            ST_HOLD:  if (w_out_hs)           w_state_next = ST_ACCUM;
            default:                          w_state_next = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_ACCUM;
            r_p         <= '0;
            r_p_valid   <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_p_valid <= w_in_hs;
            if (w_in_hs) begin
                r_p <= w_prod_ext;
            end

            if (w_out_hs) begin
                r_acc <= '0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else if (r_p_valid) begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + 1'b1;
                if (w_carry) begin
                    r_ovf <= 1'b1;
                end
            end

            if (r_state == ST_DRAIN && !r_p_valid) begin
                r_out_valid <= 1'b1;
                r_out_sum   <= r_acc;
                r_out_count <= r_cnt;
                r_out_ovf   <= r_ovf;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_count = r_out_count;
    assign out_ovf   = r_out_ovf;

endmodule

`default_nettype wire

// File: tb/tb_mac_accumulator.sv
// ============================================================================
//  Module   : tb_mac_accumulator
//  Function : Directed self-checking bench for mac_accumulator.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_accumulator;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic [7:0]  out_count;
    logic        out_ovf;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] q_sum[$];
    logic [7:0]  q_cnt[$];
    logic        q_ovf[$];

    mac_accumulator #(.bit_width(8), .acc_width(16), .cnt_width(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records every result that will be taken at the coming rising edge.
    always @(negedge clk) begin
        #1;
        if (rst_n && out_valid && out_ready) begin
            q_sum.push_back(out_sum);
            q_cnt.push_back(out_count);
            q_ovf.push_back(out_ovf);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic last);
        int n;
        n        = 0;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", 0, 1);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic get_result(input string tag, input logic [31:0] es,
                              input logic [31:0] ec, input logic [31:0] eo);
        int n;
        n = 0;
        while (q_sum.size() == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q_sum.size() == 0) begin
            check({tag, "_timeout"}, 0, 1);
        end else begin
            check({tag, "_sum"},   32'(q_sum.pop_front()), es);
            check({tag, "_count"}, 32'(q_cnt.pop_front()), ec);
            check({tag, "_ovf"},   32'(q_ovf.pop_front()), eo);
        end
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        check("rst_in_ready",  32'(in_ready),  1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_sum",   32'(out_sum),   0);
        check("rst_out_count", 32'(out_count), 0);
        check("rst_out_ovf",   32'(out_ovf),   0);

        // Three-term burst with latency probe on the last beat.
        send_beat(8'd3, 8'd4, 1'b0);
        send_beat(8'd5, 8'd6, 1'b0);
        send_beat(8'd7, 8'd8, 1'b1);
        in_valid = 1'b0;
        check("t1_ready_drain", 32'(in_ready),  0);
        check("t1_valid_t0",    32'(out_valid), 0);
        @(negedge clk);
        check("t1_valid_t1",    32'(out_valid), 0);
        @(negedge clk);
        check("t1_valid_t2",    32'(out_valid), 1);
        get_result("t1", 98, 3, 0);

        // Single beat with truncated product.
        send_beat(8'd20, 8'd20, 1'b1);
        in_valid = 1'b0;
        get_result("t2", 144, 1, 0);

        // 300 beats of 255*1 overflow the 16-bit accumulator.
        for (int i = 1; i <= 300; i++) begin
            send_beat(8'd255, 8'd1, (i == 300));
        end
        in_valid = 1'b0;
`ifdef MAC_SATURATE_EN
        get_result("t3", 65535, 44, 1);
`else
        get_result("t3", 10964, 44, 1);
`endif

        // Back-pressure: result held while inputs are ignored.
        out_ready = 1'b0;
        send_beat(8'd2, 8'd3, 1'b1);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t4_valid_seen", 32'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            in_a     = 8'($urandom_range(0, 255));
            in_b     = 8'($urandom_range(0, 255));
            in_last  = 1'b1;
            @(negedge clk);
            check("t4_hold_valid", 32'(out_valid), 1);
            check("t4_hold_sum",   32'(out_sum),   6);
            check("t4_hold_count", 32'(out_count), 1);
            check("t4_hold_ready", 32'(in_ready),  0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("t4_ready_after", 32'(in_ready),  1);
        check("t4_valid_after", 32'(out_valid), 0);
        get_result("t4", 6, 1, 0);
        send_beat(8'd2, 8'd2, 1'b1);
        in_valid = 1'b0;
        get_result("t4b", 4, 1, 0);

        // Reset in the middle of a burst discards it.
        send_beat(8'd9, 8'd9, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_ready", 32'(in_ready),  1);
        check("t5_valid", 32'(out_valid), 0);
        repeat (6) @(negedge clk);
        check("t5_no_output", 32'(q_sum.size()), 0);
        send_beat(8'd1, 8'd1, 1'b1);
        in_valid = 1'b0;
        get_result("t5", 1, 1, 0);

        // Back-to-back bursts with in_valid held high throughout.
        send_beat(8'd1, 8'd1, 1'b0);
        send_beat(8'd2, 8'd2, 1'b1);
        send_beat(8'd3, 8'd3, 1'b1);
        in_valid = 1'b0;
        get_result("t6a", 5, 2, 0);
        get_result("t6b", 9, 1, 0);
        repeat (5) @(negedge clk);
        check("t6_no_extra", 32'(q_sum.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
